// File: rtl/acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acc_pkg
// Description : Shared definitions for the accumulator / operation unit:
//               op codes, default datapath width, flag bus indices and the
//               multiplier sequencer state type.
// Revision    : 1.0 - initial release
// ============================================================================
package acc_pkg;

    localparam int DEFAULT_WIDTH = 16;

    // Operation codes driven on Op by the control unit
    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LD  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_CLR = 3'b111;

    // Bit positions inside the packed status-flag register
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;
    localparam int FLAG_W = 4;

    typedef enum logic [0:0] {
        MUL_IDLE = 1'b0,
        MUL_RUN  = 1'b1
    } mulState_t;

endpackage
`default_nettype wire

// File: rtl/acc_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : acc_mul_seq
// Description : Unsigned shift-add sequential multiplier, one iteration per
//               falling clock edge, WIDTH iterations per product.
// Ports       : Clock       - system clock (state updates on falling edge)
//               Reset       - asynchronous active-low reset
//               start       - accept a and b (ignored while busy)
//               a, b        - multiplicand / multiplier
//               busy        - iterations in progress
//               done        - one-cycle pulse after the final iteration
//               finalStep   - the coming edge performs the final iteration
//               product     - partial product including the iteration done
//                             at the coming edge; full result when finalStep
// Revision    : 1.0 - initial release
// ============================================================================
module acc_mul_seq
    import acc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic                 finalStep,
    output logic [2*WIDTH-1:0]   product
);

    mulState_t            r_state;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_prod;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_done;

    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_prodNext;
    logic                 w_last;

    // The multiplicand register is pre-shifted each iteration, so the
    // addend is simply gated by the current multiplier LSB.
    assign w_addend   = r_mplier[0] ? r_mcand : '0;
    assign w_prodNext = r_prod + w_addend;
    assign w_last     = (r_state == MUL_RUN) && (r_cnt == CNT_W'(1));

    assign busy      = (r_state == MUL_RUN);
    assign done      = r_done;
    assign finalStep = w_last;
    assign product   = w_prodNext;

    always_ff @(negedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state  <= MUL_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                MUL_IDLE: begin
                    if (start) begin
                        r_mcand  <= {{WIDTH{1'b0}}, a};
                        r_mplier <= b;
                        r_prod   <= '0;
                        r_cnt    <= CNT_W'(WIDTH);
                        r_state  <= MUL_RUN;
                    end
                end
                MUL_RUN: begin
                    r_prod   <= w_prodNext;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - CNT_W'(1);
                    if (w_last) begin
                        r_state <= MUL_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= MUL_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/acc_unit.sv
`default_nettype none
// ============================================================================
// Module      : acc_unit
// Description : Accumulator with integrated single-cycle ALU (LD/ADD/SUB/
//               SHL/SHR/CLR), sequential unsigned multiply and registered
//               Z/N/C/V status flags.
// Ports       : Clock  - system clock (state updates on falling edge)
//               Reset  - asynchronous active-low reset
//               SelA   - operand from the operand-select mux
//               WrAcc  - execute Op at the falling edge when not Busy
//               Op     - operation code (see acc_pkg)
//               AccOut - accumulator contents
//               Busy   - multiply in progress
//               Done   - one-cycle pulse when the product is written
//               FlagZ/FlagN/FlagC/FlagV - status flags
// Revision    : 1.0 - initial release
// ============================================================================
module acc_unit
    import acc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [WIDTH-1:0]  SelA,
    input  logic              WrAcc,
    input  logic [2:0]        Op,
    output logic [WIDTH-1:0]  AccOut,
    output logic              Busy,
    output logic              Done,
    output logic              FlagZ,
    output logic              FlagN,
    output logic              FlagC,
    output logic              FlagV
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0]    r_acc;
    logic [FLAG_W-1:0]   r_flags;

    logic                w_exec;
    logic                w_mulBusy;
    logic                w_mulDone;
    logic                w_mulFinal;
    logic [2*WIDTH-1:0]  w_mulProd;
    logic [WIDTH:0]      w_sum;
    logic [WIDTH-1:0]    w_diff;
    logic [WIDTH-1:0]    w_aluRes;
    logic                w_aluC;
    logic                w_aluV;
    logic                w_aluWrite;

    // Strobes arriving while the multiplier runs are dropped, not queued.
    assign w_exec = WrAcc && !w_mulBusy;

    acc_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .Clock     (Clock),
        .Reset     (Reset),
        .start     (w_exec && (Op == OP_MUL)),
        .a         (r_acc),
        .b         (SelA),
        .busy      (w_mulBusy),
        .done      (w_mulDone),
        .finalStep (w_mulFinal),
        .product   (w_mulProd)
    );

    assign w_sum  = {1'b0, r_acc} + {1'b0, SelA};
    assign w_diff = r_acc - SelA;

    always_comb begin
        w_aluRes   = r_acc;
        w_aluC     = 1'b0;
        w_aluV     = 1'b0;
        w_aluWrite = 1'b0;
        case (Op)
            OP_LD: begin
                w_aluRes   = SelA;
                w_aluWrite = 1'b1;
            end
            OP_ADD: begin
                w_aluRes   = w_sum[MSB:0];
                w_aluC     = w_sum[WIDTH];
                w_aluV     = (r_acc[MSB] == SelA[MSB]) && (w_sum[MSB] != r_acc[MSB]);
                w_aluWrite = 1'b1;
            end
            OP_SUB: begin
                w_aluRes   = w_diff;
                w_aluC     = (r_acc < SelA);
                w_aluV     = (r_acc[MSB] != SelA[MSB]) && (w_diff[MSB] != r_acc[MSB]);
                w_aluWrite = 1'b1;
            end
            OP_SHL: begin
                w_aluRes   = {r_acc[MSB-1:0], 1'b0};
                w_aluC     = r_acc[MSB];
                w_aluWrite = 1'b1;
            end
            OP_SHR: begin
                w_aluRes   = {r_acc[MSB], r_acc[MSB:1]};
                w_aluC     = r_acc[0];
                w_aluWrite = 1'b1;
            end
            OP_CLR: begin
                w_aluRes   = '0;
                w_aluWrite = 1'b1;
            end
            // NOP leaves everything alone; MUL writes back only at the end.
            default: w_aluWrite = 1'b0;
        endcase
    end

    // The product write-back and a single-cycle op can never coincide:
    // the former needs the multiplier busy, the latter needs it idle.
    always_ff @(negedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_acc   <= '0;
            r_flags <= '0;
        end else if (w_mulFinal) begin
            r_acc           <= w_mulProd[MSB:0];
            r_flags[FLAG_Z] <= (w_mulProd[MSB:0] == '0);
            r_flags[FLAG_N] <= w_mulProd[MSB];
            r_flags[FLAG_C] <= 1'b0;
            r_flags[FLAG_V] <= |w_mulProd[2*WIDTH-1:WIDTH];
        end else if (w_exec && w_aluWrite) begin
            r_acc           <= w_aluRes;
            r_flags[FLAG_Z] <= (w_aluRes == '0);
            r_flags[FLAG_N] <= w_aluRes[MSB];
            r_flags[FLAG_C] <= w_aluC;
            r_flags[FLAG_V] <= w_aluV;
        end
    end

    assign AccOut = r_acc;
    assign Busy   = w_mulBusy;
    assign Done   = w_mulDone;
    assign FlagZ  = r_flags[FLAG_Z];
    assign FlagN  = r_flags[FLAG_N];
    assign FlagC  = r_flags[FLAG_C];
    assign FlagV  = r_flags[FLAG_V];

endmodule
`default_nettype wire

// File: doc/acc_unit.md
Name: acc_unit

Overview:
- Parametrised accumulator with an integrated operation unit for the next BIP datapath generation.
- Replaces the plain load-only accumulator. It holds the working register and applies load, add, subtract, shift, clear or multi-cycle multiply against the SelA operand.
- It also maintains registered Z/N/C/V status flags.
- The control unit drives WrAcc/Op and uses Busy to stall while a multiply is in progress.

Parameters:
- WIDTH, 16, datapath width of operand, accumulator and result (min 4).
- CNT_W, $clog2(WIDTH)+1, multiply iteration counter width (derived, not overridden).

Ports:
- Clock  input  1  system clock; all state updates on the FALLING edge, matching existing datapath timing.
- Reset  input  1  asynchronous, active-low reset.
- SelA  input  WIDTH  operand from the operand-select mux.
- WrAcc  input  1  operation strobe; Op is executed when WrAcc=1 at a falling edge and Busy=0.
- Op  input  3  operation code (see package).
- AccOut  output  WIDTH  accumulator contents.
- Busy  output  1  multiply in progress.
- Done  output  1  one-cycle pulse when the multiply result is written.
- FlagZ  output  1  result == 0.
- FlagN  output  1  result MSB.
- FlagC  output  1  carry / borrow / shifted-out bit.
- FlagV  output  1  signed overflow (ADD/SUB); unsigned product overflow (MUL).

Behaviour:
- Reset=0, asynchronous, takes effect immediately:
  - AccOut=0, all flags=0, Busy=0, Done=0.
  - Multiplier state is cleared and any multiply in progress is aborted with no Done.
- Op encoding:
  - 000 NOP: no change, flags unchanged.
  - 001 LD: Acc=SelA.
  - 010 ADD: Acc=Acc+SelA.
  - 011 SUB: Acc=Acc-SelA.
  - 100 SHL: Acc=Acc<<1, LSB=0.
  - 101 SHR: arithmetic shift right by 1, MSB replicated.
  - 110 MUL: unsigned, multi-cycle.
  - 111 CLR: Acc=0.
- Single-cycle ops: the result and flags are visible after the same falling edge that samples WrAcc=1 (latency 1 edge).
- WrAcc=0: nothing changes. Op is don't-care.
- Flags, on every executed op except NOP:
  - Z and N always reflect the new Acc.
  - ADD: C = carry out of bit WIDTH-1. V = operands have the same sign and the result sign differs.
  - SUB: C = borrow (Acc < SelA unsigned). V = operands have different signs and the result sign differs from Acc.
  - SHL: C = old MSB, V=0.
  - SHR: C = old LSB, V=0.
  - LD, CLR: C=0, V=0.
- MUL state machine: IDLE -> RUN -> IDLE.
  - IDLE, WrAcc=1 and Op=MUL at edge k:
    - Latch multiplicand = Acc and multiplier = SelA.
    - Clear the 2*WIDTH partial product and set the counter to WIDTH.
    - Busy=1 after edge k.
  - RUN, each edge: if multiplier LSB=1, add the multiplicand (shifted by the iteration) into the partial product. Shift the multiplier right and decrement the counter.
  - Final iteration at edge k+WIDTH:
    - Acc = low WIDTH bits of the product.
    - Z and N from that value, C=0, V = (high WIDTH bits != 0).
    - Busy=0 and Done=1 after edge k+WIDTH. Done clears at edge k+WIDTH+1.
  - AccOut and the flags hold their pre-MUL values throughout RUN.
  - WrAcc while Busy=1 is ignored entirely: no queuing, no error. The controller must stall on Busy.
  - A new op, including another MUL, can be accepted at edge k+WIDTH+1.
- All arithmetic is modulo 2^WIDTH. No saturation.

Decomposition:
- Package acc_pkg:
  - Op code localparams OP_NOP … OP_CLR.
  - Default WIDTH.
  - Flag index constants for a packed flags bus.
- Sub-module acc_mul_seq: shift-add sequential multiplier.
  - Inputs: Clock, Reset, start, a, b.
  - Outputs: busy, done, product[2*WIDTH-1:0].
  - Instantiated once.
- acc_unit top: holds Acc, flags, the single-cycle ALU and the write-back mux.

Test Plan (WIDTH=16):
- Reset asserted mid-activity -> AccOut=0x0000, Z=N=C=V=0, Busy=0, Done=0 immediately, without waiting for a clock edge.
- LD 0x1234 then ADD 0xEDCC -> AccOut=0x0000, Z=1, C=1, V=0. Then LD 0x7FFF, ADD 0x0001 -> 0x8000, N=1, V=1, C=0.
- LD 0x0000, SUB 0x0001 -> 0xFFFF, N=1, C=1, V=0. Then SHR -> 0xFFFF, C=1. Then LD 0x8001, SHL -> 0x0002, C=1.
- LD 0x0012, MUL 0x0034:
  - Busy high for exactly 16 cycles and AccOut held at 0x0012.
  - LD 0xAAAA issued during Busy is ignored.
  - Then AccOut=0x03A8, V=0, and a Done pulse of 1 cycle.
- LD 0x0100, MUL 0x0100 -> AccOut=0x0000, Z=1, V=1.
- Start MUL, assert Reset at RUN cycle 5 -> Busy=0, AccOut=0, no Done pulse. After release, LD 0x0005 works on the next edge.
